// File: rtl/realign_pkg.sv
// Shared widths and FSM state type for the stream realigner.
`timescale 1ns/1ps

package realign_pkg;

    localparam int WORD_W = 32;
    localparam int OFF_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } realign_state_t;

endpackage

// File: rtl/realign_funnel.sv
// Combinational funnel shifter that selects a 32-bit window out of two
// adjacent words. side=1 takes the upper half of {h,w} << offset, side=0
// takes the lower half of {w,h} >> offset; offset 0 returns h either way.
`timescale 1ns/1ps

module realign_funnel
    import realign_pkg::*;
(
    input  logic [WORD_W-1:0] h,
    input  logic [WORD_W-1:0] w,
    input  logic              side,
    input  logic [OFF_W-1:0]  offset,
    output logic [WORD_W-1:0] o_f
);

    // Complementary shift amount; 32 when offset is 0, which shifts w out
    // entirely so only h survives.
    logic [OFF_W:0] w_comp;

    assign w_comp = (OFF_W+1)'(WORD_W) - {1'b0, offset};

    // Window select: the two halves are shifted toward each other and merged.
    always_comb begin
        o_f = '0;
        if (side) begin
            o_f = (h << offset) | (w >> w_comp);
        end else begin
            o_f = (h >> offset) | (w << w_comp);
        end
    end

endmodule

// File: rtl/stream_realign.sv
// Stream realigner: re-windows a packet of 32-bit words at a latched bit
// offset, using the previous word as the hold context.
// Build option: define REALIGN_FLUSH_EN to append one flush word F(hold,0)
// after the last input word; otherwise the output made from the last input
// word carries out_last.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; inputs ignored, no output
// PRIME  | accepting first word into hold, no output yet
// STREAM | one output per accepted word, F(hold,w), then hold <= w
// FLUSH  | no input; emit pending flush word (if any), drain last output
`timescale 1ns/1ps

module stream_realign
    import realign_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_side,
    input  logic [OFF_W-1:0]  cfg_offset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);

    realign_state_t    r_state, w_state_nxt;
    logic [WORD_W-1:0] r_hold, w_hold_nxt;
    logic              r_side, w_side_nxt;
    logic [OFF_W-1:0]  r_off, w_off_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic [WORD_W-1:0] r_out_data, w_out_data_nxt;
    logic              r_out_last, w_out_last_nxt;
    logic              r_flush_pend, w_flush_pend_nxt;

    logic              w_in_ready;
    logic              w_in_acc;
    logic              w_out_acc;
    logic [WORD_W-1:0] w_fun_h;
    logic [WORD_W-1:0] w_fun_w;
    logic [WORD_W-1:0] w_fun;

    assign w_in_acc  = in_valid && w_in_ready;
    assign w_out_acc = r_out_valid && out_ready;

    // In PRIME the incoming word is its own context (single-word packet gives
    // F(w,0)); in STREAM the new word pairs with hold; in FLUSH hold pairs
    // with zero.
    assign w_fun_h = (r_state == PRIME)  ? in_data : r_hold;
    assign w_fun_w = (r_state == STREAM) ? in_data : '0;

    realign_funnel u_funnel (
        .h      (w_fun_h),
        .w      (w_fun_w),
        .side   (r_side),
        .offset (r_off),
        .o_f    (w_fun)
    );

    // Next-state and datapath update; everything holds unless a case changes it.
    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold;
        w_side_nxt       = r_side;
        w_off_nxt        = r_off;
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_out_last_nxt   = r_out_last;
        w_flush_pend_nxt = r_flush_pend;
        w_in_ready       = 1'b0;

        if (w_out_acc) begin
            w_out_valid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_side_nxt       = cfg_side;
                    w_off_nxt        = cfg_offset;
                    w_hold_nxt       = '0;
                    w_flush_pend_nxt = 1'b0;
                    w_state_nxt      = PRIME;
                end
            end

            PRIME: begin
                w_in_ready = 1'b1;
                if (w_in_acc) begin
                    w_hold_nxt = in_data;
                    if (in_last) begin
                        // Single-word packet: the only output is F(w,0), in
                        // both builds, so no flush word is scheduled.
                        w_out_valid_nxt  = 1'b1;
                        w_out_data_nxt   = w_fun;
                        w_out_last_nxt   = 1'b1;
                        w_flush_pend_nxt = 1'b0;
                        w_state_nxt      = FLUSH;
                    end else begin
                        w_state_nxt = STREAM;
                    end
                end
            end

            STREAM: begin
                w_in_ready = !r_out_valid || out_ready;
                if (w_in_acc) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = w_fun;
                    w_hold_nxt      = in_data;
                    w_out_last_nxt  = 1'b0;
                    if (in_last) begin
                        w_state_nxt = FLUSH;
`ifdef REALIGN_FLUSH_EN
                        w_flush_pend_nxt = 1'b1;
`else
                        w_out_last_nxt   = 1'b1;
                        w_flush_pend_nxt = 1'b0;
`endif
                    end
                end
            end

            FLUSH: begin
                if (r_flush_pend) begin
                    if (!r_out_valid || out_ready) begin
                        w_out_valid_nxt  = 1'b1;
                        w_out_data_nxt   = w_fun;
                        w_out_last_nxt   = 1'b1;
                        w_flush_pend_nxt = 1'b0;
                    end
                end else if (!r_out_valid || w_out_acc) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_side       <= 1'b0;
            r_off        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_side       <= w_side_nxt;
            r_off        <= w_off_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_last   <= w_out_last_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_stream_realign.sv
// Directed bench for stream_realign with an expected-output queue.
// Expectations follow REALIGN_FLUSH_EN the same way the design build does.
`timescale 1ns/1ps

module tb_stream_realign;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cfg_side;
    logic [4:0]  cfg_offset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;

    logic [32:0] q[$];          // {last, data}
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    stream_realign dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_side   (cfg_side),
        .cfg_offset (cfg_offset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    function automatic logic [31:0] f_ref(input logic [31:0] h, input logic [31:0] w,
                                          input logic side, input logic [4:0] off);
        logic [63:0] t;
        if (side) begin
            t = {h, w} << off;
            return t[63:32];
        end
        t = {w, h} >> off;
        return t[31:0];
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic last, input logic [31:0] d);
        q.push_back({last, d});
    endtask

    // Tail of a multi-word packet whose last two words are h then w.
    task automatic expect_tail(input logic [31:0] h, input logic [31:0] w,
                               input logic side, input logic [4:0] off);
`ifdef REALIGN_FLUSH_EN
        expect_word(1'b0, f_ref(h, w, side, off));
        expect_word(1'b1, f_ref(w, 32'h0, side, off));
`else
        expect_word(1'b1, f_ref(h, w, side, off));
`endif
    endtask

    // Scoreboard: every output handshake pops and compares one expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_output: observed=%h last=%b expected=none", out_data, out_last);
            end
            if (q.size() != 0) begin
                logic [32:0] e;
                e = q.pop_front();
                chk("out_data", {1'b0, out_data}, {1'b0, e[31:0]});
                chk("out_last", {32'h0, out_last}, {32'h0, e[32]});
            end
        end
    end

    task automatic start_pkt(input logic side, input logic [4:0] off);
        cfg_side   = side;
        cfg_offset = off;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic push_in(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_accept_timeout", {32'h0, in_ready}, 33'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {32'h0, busy}, 33'h0);
        chk("queue_drained", 33'(q.size()), 33'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n      = 1'b0;
        start      = 1'b0;
        cfg_side   = 1'b0;
        cfg_offset = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        #2;
        chk("rst_out_valid", {32'h0, out_valid}, 33'h0);
        chk("rst_out_data",  {1'b0, out_data},   33'h0);
        chk("rst_busy",      {32'h0, busy},      33'h0);
        chk("rst_in_ready",  {32'h0, in_ready},  33'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", {32'h0, in_ready}, 33'h0);
        chk("idle_no_out",   {32'h0, out_valid}, 33'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // left window, offset 8
        start_pkt(1'b1, 5'd8);
        chk("busy_after_start", {32'h0, busy}, 33'h1);
`ifdef REALIGN_FLUSH_EN
        expect_word(1'b0, 32'h22334455);
        expect_word(1'b1, 32'h66778800);
`else
        expect_word(1'b1, 32'h22334455);
`endif
        push_in(32'h11223344, 1'b0);
        push_in(32'h55667788, 1'b1);
        wait_idle();

        // right window, offset 8
        start_pkt(1'b0, 5'd8);
`ifdef REALIGN_FLUSH_EN
        expect_word(1'b0, 32'h88112233);
        expect_word(1'b1, 32'h00556677);
`else
        expect_word(1'b1, 32'h88112233);
`endif
        push_in(32'h11223344, 1'b0);
        push_in(32'h55667788, 1'b1);
        wait_idle();

        // offset 0: passthrough delayed by one word, latency and throughput
        start_pkt(1'b1, 5'd0);
        expect_word(1'b0, 32'hA0000001);
        expect_word(1'b0, 32'hB0000002);
`ifdef REALIGN_FLUSH_EN
        expect_word(1'b0, 32'hC0000003);
        expect_word(1'b1, 32'hD0000004);
`else
        expect_word(1'b1, 32'hC0000003);
`endif
        push_in(32'hA0000001, 1'b0);
        c0 = cyc;
        push_in(32'hB0000002, 1'b0);
        chk("latency_valid", {32'h0, out_valid}, 33'h1);
        chk("latency_data",  {1'b0, out_data},   {1'b0, 32'hA0000001});
        push_in(32'hC0000003, 1'b0);
        push_in(32'hD0000004, 1'b1);
        chk("throughput_cycles", 33'(cyc - c0), 33'd3);
        wait_idle();

        // backpressure: out_ready low for 5 cycles mid-stream
        start_pkt(1'b0, 5'd4);
        expect_word(1'b0, f_ref(32'h12345678, 32'h9ABCDEF0, 1'b0, 5'd4));
        expect_word(1'b0, f_ref(32'h9ABCDEF0, 32'h0F1E2D3C, 1'b0, 5'd4));
        expect_tail(32'h0F1E2D3C, 32'h4B5A6978, 1'b0, 5'd4);
        push_in(32'h12345678, 1'b0);
        push_in(32'h9ABCDEF0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0F1E2D3C;
        in_last   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  {32'h0, in_ready},  33'h0);
            chk("stall_out_valid", {32'h0, out_valid}, 33'h1);
            chk("stall_out_data",  {1'b0, out_data},
                {1'b0, f_ref(32'h12345678, 32'h9ABCDEF0, 1'b0, 5'd4)});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", {32'h0, in_ready}, 33'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_in(32'h4B5A6978, 1'b1);
        wait_idle();

        // reset in STREAM with an output pending
        out_ready = 1'b0;
        start_pkt(1'b1, 5'd0);
        expect_word(1'b0, 32'h01010101);
        push_in(32'h01010101, 1'b0);
        push_in(32'h02020202, 1'b0);
        chk("pre_rst_out_valid", {32'h0, out_valid}, 33'h1);
        in_valid = 1'b1;
        in_data  = 32'h03030303;
        rst_n    = 1'b0;
        #1;
        q.delete();
        chk("mid_rst_out_valid", {32'h0, out_valid}, 33'h0);
        chk("mid_rst_out_data",  {1'b0, out_data},   33'h0);
        chk("mid_rst_out_last",  {32'h0, out_last},  33'h0);
        chk("mid_rst_busy",      {32'h0, busy},      33'h0);
        chk("mid_rst_in_ready",  {32'h0, in_ready},  33'h0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_no_out",   {32'h0, out_valid}, 33'h0);
        chk("post_rst_idle",     {32'h0, busy},      33'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        start_pkt(1'b1, 5'd4);
`ifdef REALIGN_FLUSH_EN
        expect_word(1'b0, 32'h000000FF);
        expect_word(1'b1, 32'h00000000);
`else
        expect_word(1'b1, 32'h000000FF);
`endif
        push_in(32'h0000000F, 1'b0);
        push_in(32'hF0000000, 1'b1);
        wait_idle();

        // start during STREAM is ignored; config stays at side=0 offset=8
        start_pkt(1'b0, 5'd8);
        expect_word(1'b0, f_ref(32'hCAFEF00D, 32'h13579BDF, 1'b0, 5'd8));
        expect_tail(32'h13579BDF, 32'h2468ACE0, 1'b0, 5'd8);
        push_in(32'hCAFEF00D, 1'b0);
        push_in(32'h13579BDF, 1'b0);
        start_pkt(1'b1, 5'd16);
        chk("start_ignored_busy", {32'h0, busy}, 33'h1);
        push_in(32'h2468ACE0, 1'b1);
        wait_idle();

        // single-word packet
        start_pkt(1'b1, 5'd16);
        expect_word(1'b1, 32'hA5A50000);
        push_in(32'hA5A5A5A5, 1'b1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
